// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the Wishbone-style two-master bus arbiter.
// Holds the slave count, the slave base map (CH1..CH8, CLKA..CLKD),
// the arbiter state encoding, the default error read data and the
// address-to-strobe decode helpers.
package wb_bus_arbiter_pkg;

  localparam int NUM_SLAVES = 12;

  // Read data returned to a master when a transaction ends in error.
  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  // Slave base values, matched against adr[7:4].
  localparam logic [3:0] CH1_BASE  = 4'd0;
  localparam logic [3:0] CH2_BASE  = 4'd1;
  localparam logic [3:0] CH3_BASE  = 4'd2;
  localparam logic [3:0] CH4_BASE  = 4'd3;
  localparam logic [3:0] CH5_BASE  = 4'd4;
  localparam logic [3:0] CH6_BASE  = 4'd5;
  localparam logic [3:0] CH7_BASE  = 4'd6;
  localparam logic [3:0] CH8_BASE  = 4'd7;
  localparam logic [3:0] CLKA_BASE = 4'd8;
  localparam logic [3:0] CLKB_BASE = 4'd9;
  localparam logic [3:0] CLKC_BASE = 4'd10;
  localparam logic [3:0] CLKD_BASE = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_state_e;

  // One-hot slave strobe for a slave select field; unmapped selects give zero.
  function automatic logic [NUM_SLAVES-1:0] slave_decode(input logic [3:0] sel);
    logic [NUM_SLAVES-1:0] oh;
    oh = {NUM_SLAVES{1'b0}};
    case (sel)
      CH1_BASE:  oh[CH1_BASE]  = 1'b1;
      CH2_BASE:  oh[CH2_BASE]  = 1'b1;
      CH3_BASE:  oh[CH3_BASE]  = 1'b1;
      CH4_BASE:  oh[CH4_BASE]  = 1'b1;
      CH5_BASE:  oh[CH5_BASE]  = 1'b1;
      CH6_BASE:  oh[CH6_BASE]  = 1'b1;
      CH7_BASE:  oh[CH7_BASE]  = 1'b1;
      CH8_BASE:  oh[CH8_BASE]  = 1'b1;
      CLKA_BASE: oh[CLKA_BASE] = 1'b1;
      CLKB_BASE: oh[CLKB_BASE] = 1'b1;
      CLKC_BASE: oh[CLKC_BASE] = 1'b1;
      CLKD_BASE: oh[CLKD_BASE] = 1'b1;
      default:   oh = {NUM_SLAVES{1'b0}};
    endcase
    return oh;
  endfunction

  // True when the select field addresses an existing slave.
  function automatic logic slave_valid(input logic [3:0] sel);
    return (sel <= CLKD_BASE);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog for the bus arbiter.
// Counts enabled cycles since the last clear and flags the cycle in which
// the TIMEOUT-th enabled cycle is in progress, so the owner can abort at
// the end of that cycle.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous active-low reset
//   clear   - return the count to zero
//   enable  - count this cycle
//   expired - this enabled cycle is the TIMEOUT-th one
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter; saturates at TIMEOUT so it can never wrap back to zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable && (cnt_r != MAX_CNT)) begin
      cnt_r <= cnt_r + ONE_CNT;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == LAST_CNT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, twelve-slave bus arbiter with round-robin arbitration,
// address decode and a transaction watchdog.
// A request accepted in IDLE is driven to the selected slave during BUSY;
// the slave ack, an unmapped address or a watchdog timeout ends it, and
// the result is presented to the granted master for one DONE cycle.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-low reset
//   mX_stb_i/we_i/adr_i/dat_i - master request (m0 host, m1 sequencer)
//   mX_dat_o/ack_o/err_o   - master response (err valid with ack)
//   s_stb_o                - one-hot slave strobe
//   s_we_o/adr_o/dat_o     - shared slave request fields
//   s_dat_i/s_ack_i        - per-slave read data and acknowledge
//   grant_o                - one-hot current owner, zero when idle
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m0_stb_i,
  input  logic                      m1_stb_i,
  input  logic                      m0_we_i,
  input  logic                      m1_we_i,
  input  logic [7:0]                m0_adr_i,
  input  logic [7:0]                m1_adr_i,
  input  logic [7:0]                m0_dat_i,
  input  logic [7:0]                m1_dat_i,
  output logic [7:0]                m0_dat_o,
  output logic [7:0]                m1_dat_o,
  output logic                      m0_ack_o,
  output logic                      m1_ack_o,
  output logic                      m0_err_o,
  output logic                      m1_err_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_adr_o,
  output logic [7:0]                s_dat_o,
  input  logic [8*NUM_SLAVES-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  output logic [1:0]                grant_o
);

  arb_state_e            state_r, state_nxt;
  logic [1:0]            grant_r, grant_nxt;
  logic                  last_m1_r, last_m1_nxt;
  logic [7:0]            adr_r, adr_nxt;
  logic                  we_r, we_nxt;
  logic [7:0]            wdat_r, wdat_nxt;
  logic [NUM_SLAVES-1:0] s_stb_r, s_stb_nxt;
  logic [7:0]            m0_dat_r, m0_dat_nxt;
  logic [7:0]            m1_dat_r, m1_dat_nxt;
  logic                  m0_ack_r, m0_ack_nxt;
  logic                  m1_ack_r, m1_ack_nxt;
  logic                  m0_err_r, m0_err_nxt;
  logic                  m1_err_r, m1_err_nxt;

  logic                  sel_ack_s;
  logic [7:0]            sel_dat_s;
  logic                  pick_m1_s;
  logic                  fin_s;
  logic                  fin_err_s;
  logic [7:0]            fin_dat_s;
  logic                  wd_clear_s;
  logic                  wd_enable_s;
  logic                  wd_expired_s;

  // Only the strobed slave can complete the transaction; other acks are masked.
  assign sel_ack_s = |(s_ack_i & s_stb_r);

  // Read data mux driven by the registered one-hot strobe.
  always_comb begin
    sel_dat_s = 8'h00;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      sel_dat_s = sel_dat_s | ({8{s_stb_r[n]}} & s_dat_i[8*n +: 8]);
    end
  end

  // On a tie the master not served last wins; otherwise the sole requester wins.
  assign pick_m1_s = m1_stb_i && (!m0_stb_i || !last_m1_r);

  assign wd_clear_s  = (state_r != ST_BUSY);
  assign wd_enable_s = (state_r == ST_BUSY) && !sel_ack_s;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // State and registered-output update.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      grant_r   <= 2'b00;
      last_m1_r <= 1'b1;
      adr_r     <= 8'h00;
      we_r      <= 1'b0;
      wdat_r    <= 8'h00;
      s_stb_r   <= {NUM_SLAVES{1'b0}};
      m0_dat_r  <= 8'h00;
      m1_dat_r  <= 8'h00;
      m0_ack_r  <= 1'b0;
      m1_ack_r  <= 1'b0;
      m0_err_r  <= 1'b0;
      m1_err_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      grant_r   <= grant_nxt;
      last_m1_r <= last_m1_nxt;
      adr_r     <= adr_nxt;
      we_r      <= we_nxt;
      wdat_r    <= wdat_nxt;
      s_stb_r   <= s_stb_nxt;
      m0_dat_r  <= m0_dat_nxt;
      m1_dat_r  <= m1_dat_nxt;
      m0_ack_r  <= m0_ack_nxt;
      m1_ack_r  <= m1_ack_nxt;
      m0_err_r  <= m0_err_nxt;
      m1_err_r  <= m1_err_nxt;
    end
  end

  // Next-state and next-output logic for IDLE -> BUSY -> DONE -> IDLE.
  always_comb begin
    state_nxt   = state_r;
    grant_nxt   = grant_r;
    last_m1_nxt = last_m1_r;
    adr_nxt     = adr_r;
    we_nxt      = we_r;
    wdat_nxt    = wdat_r;
    s_stb_nxt   = s_stb_r;
    m0_dat_nxt  = m0_dat_r;
    m1_dat_nxt  = m1_dat_r;
    m0_ack_nxt  = 1'b0;
    m1_ack_nxt  = 1'b0;
    m0_err_nxt  = 1'b0;
    m1_err_nxt  = 1'b0;
    fin_s       = 1'b0;
    fin_err_s   = 1'b0;
    fin_dat_s   = ERR_DATA;

    case (state_r)
      ST_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          state_nxt   = ST_BUSY;
          last_m1_nxt = pick_m1_s;
          if (pick_m1_s) begin
            grant_nxt = 2'b10;
            adr_nxt   = m1_adr_i;
            we_nxt    = m1_we_i;
            wdat_nxt  = m1_dat_i;
            s_stb_nxt = slave_decode(m1_adr_i[7:4]);
          end else begin
            grant_nxt = 2'b01;
            adr_nxt   = m0_adr_i;
            we_nxt    = m0_we_i;
            wdat_nxt  = m0_dat_i;
            s_stb_nxt = slave_decode(m0_adr_i[7:4]);
          end
        end else begin
          state_nxt = ST_IDLE;
          grant_nxt = 2'b00;
          s_stb_nxt = {NUM_SLAVES{1'b0}};
        end
      end

      ST_BUSY: begin
        // Priority: unmapped address, then slave ack, then watchdog.
        if (!slave_valid(adr_r[7:4])) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          fin_dat_s = ERR_DATA;
        end else if (sel_ack_s) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b0;
          fin_dat_s = sel_dat_s;
        end else if (wd_expired_s) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          fin_dat_s = ERR_DATA;
        end else begin
          fin_s     = 1'b0;
          fin_err_s = 1'b0;
          fin_dat_s = ERR_DATA;
        end

        if (fin_s) begin
          state_nxt = ST_DONE;
          s_stb_nxt = {NUM_SLAVES{1'b0}};
          if (grant_r[1]) begin
            m1_ack_nxt = 1'b1;
            m1_err_nxt = fin_err_s;
            m1_dat_nxt = fin_dat_s;
          end else begin
            m0_ack_nxt = 1'b1;
            m0_err_nxt = fin_err_s;
            m0_dat_nxt = fin_dat_s;
          end
        end else begin
          state_nxt = ST_BUSY;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
        s_stb_nxt = {NUM_SLAVES{1'b0}};
      end

      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
        s_stb_nxt = {NUM_SLAVES{1'b0}};
      end
    endcase
  end

  assign m0_dat_o = m0_dat_r;
  assign m1_dat_o = m1_dat_r;
  assign m0_ack_o = m0_ack_r;
  assign m1_ack_o = m1_ack_r;
  assign m0_err_o = m0_err_r;
  assign m1_err_o = m1_err_r;
  assign s_stb_o  = s_stb_r;
  assign s_we_o   = we_r;
  assign s_adr_o  = adr_r[3:0];
  assign s_dat_o  = wdat_r;
  assign grant_o  = grant_r;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter.
module tb_wb_bus_arbiter;

  logic        clk;
  logic        rst_i;
  logic        m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
  logic [7:0]  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
  logic [7:0]  m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [11:0] s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_adr_o;
  logic [7:0]  s_dat_o;
  logic [95:0] s_dat_i;
  logic [11:0] s_ack_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
    .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
    .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
    .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Slave n acks with data d for the current BUSY cycle.
  task automatic slave_reply(input int n, input logic [7:0] d);
    s_ack_i = 12'h000;
    s_ack_i[n] = 1'b1;
    s_dat_i[8*n +: 8] = d;
    step();
    s_ack_i = 12'h000;
  endtask

  initial begin
    int cycles;
    rst_i = 1'b0;
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_adr_i = 8'h00; m1_adr_i = 8'h00; m0_dat_i = 8'h00; m1_dat_i = 8'h00;
    s_dat_i = 96'h0; s_ack_i = 12'h000;
    step();
    step();
    check_eq("rst_grant", grant_o, 2'b00);
    check_eq("rst_stb", s_stb_o, 12'h000);
    check_eq("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);
    rst_i = 1'b1;

    // m0 write to slave 3, reg 1, ack in the first BUSY cycle
    m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 8'h31; m0_dat_i = 8'hA5;
    step();
    check_eq("wr_stb", s_stb_o, 12'h008);
    check_eq("wr_fields", {s_we_o, s_adr_o, s_dat_o}, {1'b1, 4'h1, 8'hA5});
    check_eq("wr_grant", grant_o, 2'b01);
    check_eq("wr_early_ack", m0_ack_o, 1'b0);
    slave_reply(3, 8'h00);
    check_eq("wr_ack", {m0_ack_o, m0_err_o, m1_ack_o}, 3'b100);
    check_eq("wr_done_stb", s_stb_o, 12'h000);
    step();
    m0_stb_i = 1'b0; m0_we_i = 1'b0;
    check_eq("wr_ack_pulse", m0_ack_o, 1'b0);
    check_eq("wr_idle_grant", grant_o, 2'b00);

    // tie after m0 was served: m1 wins, then m0
    m0_stb_i = 1'b1; m0_adr_i = 8'h20;
    m1_stb_i = 1'b1; m1_adr_i = 8'h21;
    step();
    check_eq("rr_grant_m1", grant_o, 2'b10);
    check_eq("rr_m1_fields", {s_stb_o, s_adr_o}, {12'h004, 4'h1});
    slave_reply(2, 8'h77);
    check_eq("rr_m1_resp", {m1_ack_o, m1_dat_o, m0_ack_o}, {1'b1, 8'h77, 1'b0});
    step();
    m1_stb_i = 1'b0;
    step();
    check_eq("rr_grant_m0", grant_o, 2'b01);
    slave_reply(2, 8'h66);
    check_eq("rr_m0_resp", {m0_ack_o, m0_dat_o, m1_dat_o}, {1'b1, 8'h66, 8'h77});
    step();
    m0_stb_i = 1'b0;

    // after reset, a tie on slave 0 serves m0 then m1
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    m0_stb_i = 1'b1; m0_adr_i = 8'h00;
    m1_stb_i = 1'b1; m1_adr_i = 8'h00;
    step();
    check_eq("tie_grant_m0", {grant_o, s_stb_o}, {2'b01, 12'h001});
    slave_reply(0, 8'h11);
    check_eq("tie_m0_resp", {m0_ack_o, m0_dat_o, m1_ack_o}, {1'b1, 8'h11, 1'b0});
    step();
    m0_stb_i = 1'b0;
    step();
    check_eq("tie_grant_m1", {grant_o, s_stb_o}, {2'b10, 12'h001});
    slave_reply(0, 8'h22);
    check_eq("tie_m1_resp", {m1_ack_o, m1_dat_o, m0_ack_o}, {1'b1, 8'h22, 1'b0});
    check_eq("tie_m0_hold", m0_dat_o, 8'h11);
    step();
    m1_stb_i = 1'b0;

    // m1 reads an unmapped slave
    m1_stb_i = 1'b1; m1_adr_i = 8'hE0;
    step();
    check_eq("bad_stb", {grant_o, s_stb_o}, {2'b10, 12'h000});
    step();
    check_eq("bad_resp", {m1_ack_o, m1_err_o, m1_dat_o}, {1'b1, 1'b1, 8'hFF});
    step();
    m1_stb_i = 1'b0;

    // m0 reads slave 5, which never acks; an unselected slave acks throughout
    m0_stb_i = 1'b1; m0_adr_i = 8'h50;
    s_ack_i = 12'h001;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m0_ack_o) break;
      if (s_stb_o == 12'h020) cycles++;
    end
    check_eq("to_stb_cycles", cycles, 16);
    check_eq("to_resp", {m0_ack_o, m0_err_o, m0_dat_o}, {1'b1, 1'b1, 8'hFF});
    s_ack_i = 12'h000;
    step();
    m0_stb_i = 1'b0;
    step();

    // slave 5 acks in the cycle the watchdog would expire
    m0_stb_i = 1'b1; m0_adr_i = 8'h50;
    for (int i = 0; i < 16; i++) step();
    check_eq("race_stb", s_stb_o, 12'h020);
    slave_reply(5, 8'h5A);
    check_eq("race_resp", {m0_ack_o, m0_err_o, m0_dat_o}, {1'b1, 1'b0, 8'h5A});
    step();
    m0_stb_i = 1'b0;
    step();

    // reset in the second BUSY cycle of an m1 write
    m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 8'h23; m1_dat_i = 8'h3C;
    step();
    step();
    check_eq("rb_busy", {grant_o, s_stb_o, s_we_o}, {2'b10, 12'h004, 1'b1});
    rst_i = 1'b0;
    m1_stb_i = 1'b0; m1_we_i = 1'b0;
    step();
    check_eq("rb_outs", {s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o},
             {12'h000, 1'b0, 4'h0, 8'h00, 2'b00});
    check_eq("rb_master", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o},
             {4'h0, 8'h00, 8'h00});
    rst_i = 1'b1;
    m0_stb_i = 1'b1; m0_adr_i = 8'h10;
    m1_stb_i = 1'b1; m1_adr_i = 8'h10;
    step();
    check_eq("rb_no_ack", m1_ack_o, 1'b0);
    check_eq("rb_grant_m0", {grant_o, s_stb_o}, {2'b01, 12'h002});
    slave_reply(1, 8'h99);
    check_eq("rb_m0_resp", {m0_ack_o, m0_dat_o}, {1'b1, 8'h99});
    step();
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
